// File: rtl/model_pkg.sv
// Shared constants and loader state encoding, so the weight loader and the model
// agree on word and weight-register widths.
package model_pkg;

  localparam int unsigned MODEL_WORD_B    = 32;
  localparam int unsigned MODEL_WEIGHTS_B = 10496;

  typedef logic [1:0] wl_state_t;

  localparam wl_state_t WL_IDLE      = 2'd0;
  localparam wl_state_t WL_WAIT_WORD = 2'd1;
  localparam wl_state_t WL_SHIFT     = 2'd2;
  localparam wl_state_t WL_DONE      = 2'd3;

endpackage

// File: rtl/wl_piso.sv
// Parallel-in serial-out word buffer with per-word and total shifted-bit counters.
// The buffer shifts LSB-first; counters are sized so they never wrap during a load.
module wl_piso
  import model_pkg::*;
#(
  parameter int unsigned WORD_B    = MODEL_WORD_B,
  parameter int unsigned WEIGHTS_B = MODEL_WEIGHTS_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_B-1:0] data,
  output logic              lsb_next_c,
  output logic              word_last_c,
  output logic              total_last_c
);

  localparam int unsigned WCNT_W = $clog2(WORD_B + 1);
  localparam int unsigned TCNT_W = $clog2(WEIGHTS_B + 1);

  logic [WORD_B-1:0] buffer_q, buffer_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [TCNT_W-1:0] total_cnt_q, total_cnt_d;

  // Load restarts the word count; the total count only restarts on clr.
  always_comb begin
    buffer_d    = buffer_q;
    word_cnt_d  = word_cnt_q;
    total_cnt_d = total_cnt_q;
    if (clr) begin
      total_cnt_d = '0;
    end
    if (load) begin
      buffer_d   = data;
      word_cnt_d = '0;
    end else if (shift) begin
      buffer_d    = buffer_q >> 1;
      word_cnt_d  = word_cnt_q + WCNT_W'(1);
      total_cnt_d = total_cnt_q + TCNT_W'(1);
    end
  end

  // The bit that will sit at the buffer LSB next cycle, for a registered k.
  assign lsb_next_c   = buffer_d[0];
  assign word_last_c  = (word_cnt_q == WCNT_W'(WORD_B - 1));
  assign total_last_c = (total_cnt_q == TCNT_W'(WEIGHTS_B - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q    <= '0;
      word_cnt_q  <= '0;
      total_cnt_q <= '0;
    end else begin
      buffer_q    <= buffer_d;
      word_cnt_q  <= word_cnt_d;
      total_cnt_q <= total_cnt_d;
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams words from a valid/ready source into the model's serial weight register.
// Optional WEIGHT_LOADER_CHECK_EN adds an XOR trailer word and a crc_err output.
module weight_loader
  import model_pkg::*;
#(
  parameter int unsigned WORD_B    = MODEL_WORD_B,
  parameter int unsigned WEIGHTS_B = MODEL_WEIGHTS_B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_B-1:0] s_data,
  output logic              copy,
  output logic              k,
  output logic              busy,
  output logic              done
`ifdef WEIGHT_LOADER_CHECK_EN
  ,
  output logic              crc_err
`endif
);

  wl_state_t state_q, state_d;

  logic s_ready_q, s_ready_d;
  logic copy_q, copy_d;
  logic k_q, k_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic piso_clr, piso_load, piso_shift;
  logic lsb_next_c, word_last_c, total_last_c;
  logic xfer_c;

`ifdef WEIGHT_LOADER_CHECK_EN
  logic              trail_q, trail_d;
  logic [WORD_B-1:0] xor_q, xor_d;
  logic              crc_err_q, crc_err_d;
`endif

  assign xfer_c = s_valid && s_ready_q;

  wl_piso #(
    .WORD_B    (WORD_B),
    .WEIGHTS_B (WEIGHTS_B)
  ) u_piso (
    .clk          (clk),
    .rst          (rst),
    .clr          (piso_clr),
    .load         (piso_load),
    .shift        (piso_shift),
    .data         (s_data),
    .lsb_next_c   (lsb_next_c),
    .word_last_c  (word_last_c),
    .total_last_c (total_last_c)
  );

  // Next state; abort wins over a transfer or the final shift.
  always_comb begin
    state_d    = state_q;
    piso_clr   = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
`ifdef WEIGHT_LOADER_CHECK_EN
    trail_d    = trail_q;
    xor_d      = xor_q;
    crc_err_d  = 1'b0;
`endif
    case (state_q)
      WL_IDLE: begin
        if (start && !abort) begin
          state_d  = WL_WAIT_WORD;
          piso_clr = 1'b1;
`ifdef WEIGHT_LOADER_CHECK_EN
          trail_d  = 1'b0;
          xor_d    = '0;
`endif
        end
      end
      WL_WAIT_WORD: begin
        if (abort) begin
          state_d = WL_IDLE;
        end else if (xfer_c) begin
`ifdef WEIGHT_LOADER_CHECK_EN
          if (trail_q) begin
            state_d   = WL_DONE;
            crc_err_d = (s_data != xor_q);
          end else begin
            state_d   = WL_SHIFT;
            piso_load = 1'b1;
            xor_d     = xor_q ^ s_data;
          end
`else
          state_d   = WL_SHIFT;
          piso_load = 1'b1;
`endif
        end
      end
      WL_SHIFT: begin
        if (abort) begin
          state_d = WL_IDLE;
        end else begin
          piso_shift = 1'b1;
          // Final weight bit ends the load even mid-word; pad bits are dropped.
          if (total_last_c) begin
`ifdef WEIGHT_LOADER_CHECK_EN
            state_d = WL_WAIT_WORD;
            trail_d = 1'b1;
`else
            state_d = WL_DONE;
`endif
          end else if (word_last_c) begin
            state_d = WL_WAIT_WORD;
          end
        end
      end
      WL_DONE: begin
        state_d = WL_IDLE;
      end
      default: begin
        state_d = WL_IDLE;
      end
    endcase

    // Outputs are registered against the upcoming state.
    s_ready_d = (state_d == WL_WAIT_WORD);
    copy_d    = (state_d == WL_SHIFT);
    k_d       = copy_d && lsb_next_c;
    busy_d    = (state_d != WL_IDLE);
    done_d    = (state_d == WL_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WL_IDLE;
      s_ready_q <= 1'b0;
      copy_q    <= 1'b0;
      k_q       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef WEIGHT_LOADER_CHECK_EN
      trail_q   <= 1'b0;
      xor_q     <= '0;
      crc_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      copy_q    <= copy_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef WEIGHT_LOADER_CHECK_EN
      trail_q   <= trail_d;
      xor_q     <= xor_d;
      crc_err_q <= crc_err_d;
`endif
    end
  end

  assign s_ready = s_ready_q;
  assign copy    = copy_q;
  assign k       = k_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef WEIGHT_LOADER_CHECK_EN
  assign crc_err = crc_err_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: two instances (40 and 36 weight bits, 8-bit words)
// checked every cycle against a bit-queue / register model built from the loaded words.
module tb_weight_loader;

  localparam int unsigned WB      = 8;
  localparam int unsigned W0      = 40;
  localparam int unsigned W1      = 36;
  localparam int          N_WORDS = 5;
`ifdef WEIGHT_LOADER_CHECK_EN
  localparam int          TRAIL   = 1;
`else
  localparam int          TRAIL   = 0;
`endif
  localparam int          N_SEND  = N_WORDS + TRAIL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start   [2];
  logic          abort   [2];
  logic          s_valid [2];
  logic [WB-1:0] s_data  [2];
  logic          s_ready [2];
  logic          copy    [2];
  logic          k       [2];
  logic          busy    [2];
  logic          done    [2];
`ifdef WEIGHT_LOADER_CHECK_EN
  logic          crc_err [2];
`endif

  weight_loader #(.WORD_B(WB), .WEIGHTS_B(W0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .copy(copy[0]), .k(k[0]), .busy(busy[0]), .done(done[0])
`ifdef WEIGHT_LOADER_CHECK_EN
    , .crc_err(crc_err[0])
`endif
  );

  weight_loader #(.WORD_B(WB), .WEIGHTS_B(W1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .copy(copy[1]), .k(k[1]), .busy(busy[1]), .done(done[1])
`ifdef WEIGHT_LOADER_CHECK_EN
    , .crc_err(crc_err[1])
`endif
  );

  // Written by the stimulus process only.
  logic [7:0]  arm_words [2][6];
  logic [63:0] arm_pin   [2];
  bit          arm_nogap [2];
  bit          stop_req = 1'b0;
  int          tmo_cnt  = 0;

  // Written by the compare process only.
  int          checks = 0, errors = 0, cyc = 0, tmo_ack = 0;
  bit          rst_seen = 1'b0;
  bit          active [2], expect_idle [2], prev_copy [2], nogap [2], exp_crc [2];
  bit          exp_bits [2][64];
  int          rd_ptr [2], t_start [2];
  logic [63:0] mreg [2], exp_reg [2], pin_reg [2];

  function automatic int wt(input int d);
    return (d == 0) ? int'(W0) : int'(W1);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Expected bit stream and final register, derived straight from the word list.
  task automatic arm(input int d);
    int w;
    logic [7:0] x;
    w = wt(d);
    active[d]      = 1'b1;
    expect_idle[d] = 1'b0;
    rd_ptr[d]      = 0;
    mreg[d]        = '0;
    t_start[d]     = cyc;
    nogap[d]       = arm_nogap[d];
    pin_reg[d]     = arm_pin[d];
    exp_reg[d]     = '0;
    x              = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      exp_reg[d] = exp_reg[d] | (64'(arm_words[d][i]) << (8 * i));
      x          = x ^ arm_words[d][i];
    end
    exp_reg[d] = exp_reg[d] & ((64'd1 << w) - 64'd1);
    for (int j = 0; j < w; j++) begin
      logic [7:0] wd;
      wd             = arm_words[d][j / 8];
      exp_bits[d][j] = wd[j % 8];
    end
    exp_crc[d] = (x != arm_words[d][N_WORDS]);
  endtask

  task automatic check_dut(input int d);
    int w;
    w = wt(d);
    if (rst_seen)
      chk("reset_outs", 64'({s_ready[d], copy[d], k[d], busy[d], done[d]}), 64'd0);
    chk("ready_copy_excl", 64'(s_ready[d] & copy[d]), 64'd0);
    if (copy[d] === 1'b1) begin
      chk("copy_in_load", 64'(active[d] && (rd_ptr[d] < w)), 64'd1);
      if (active[d] && rd_ptr[d] < w) begin
        chk("k_bit", 64'(k[d]), 64'(exp_bits[d][rd_ptr[d]]));
        rd_ptr[d]++;
      end
      mreg[d] = (mreg[d] >> 1) | (64'(k[d]) << (w - 1));
    end else begin
      chk("k_idle", 64'(k[d]), 64'd0);
    end
    if (expect_idle[d]) begin
      chk("abort_idle", 64'({busy[d], copy[d], done[d]}), 64'd0);
      expect_idle[d] = 1'b0;
    end
    if (done[d] === 1'b1) begin
      chk("done_in_load", 64'(active[d]), 64'd1);
      chk("copy_count", 64'(rd_ptr[d]), 64'(w));
      chk("final_reg", mreg[d], exp_reg[d]);
      chk("reg_literal", mreg[d], pin_reg[d]);
`ifdef WEIGHT_LOADER_CHECK_EN
      chk("crc_err_done", 64'(crc_err[d]), 64'(exp_crc[d]));
`else
      chk("done_after_last_bit", 64'(prev_copy[d]), 64'd1);
`endif
      if (nogap[d])
        chk("latency", 64'(cyc - t_start[d] + 1), 64'((w + 7) / 8 + w + 2 + TRAIL));
      active[d] = 1'b0;
    end
`ifdef WEIGHT_LOADER_CHECK_EN
    else begin
      chk("crc_err_idle", 64'(crc_err[d]), 64'd0);
    end
`endif
    prev_copy[d] = copy[d];
    if (rst) begin
      active[d]      = 1'b0;
      expect_idle[d] = 1'b0;
    end else if (abort[d] && busy[d]) begin
      active[d]      = 1'b0;
      expect_idle[d] = 1'b1;
    end else if (start[d] && !busy[d] && !abort[d]) begin
      arm(d);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) check_dut(d);
      chk("done_timeout", 64'(tmo_cnt), 64'(tmo_ack));
      tmo_ack  = tmo_cnt;
      rst_seen = rst;
    end
  end

  task automatic set_words(input int d, input logic [39:0] words, input logic [7:0] trailer,
                           input logic [63:0] pin, input bit nogap_f);
    for (int i = 0; i < N_WORDS; i++) arm_words[d][i] = words[8 * i +: 8];
    arm_words[d][N_WORDS] = trailer;
    arm_pin[d]            = pin;
    arm_nogap[d]          = nogap_f;
  endtask

  task automatic send_words(input int d, input bit gaps);
    bit rdy;
    int b;
    for (int i = 0; i < N_SEND; i++) begin
      if (stop_req) break;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1 && !stop_req) begin
          s_valid[d] = 1'b0;
          @(posedge clk); #1;
        end
      end
      s_valid[d] = 1'b1;
      s_data[d]  = arm_words[d][i];
      b = 0;
      do begin
        rdy = s_ready[d];
        @(posedge clk); #1;
        b++;
      end while (!rdy && !stop_req && b < 200);
    end
    s_valid[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    int b;
    b = 0;
    while (done[d] !== 1'b1 && b < 400) begin
      @(negedge clk);
      b++;
    end
    if (done[d] !== 1'b1) tmo_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic wait_copies(input int d, input int n);
    int c, b;
    c = 0;
    b = 0;
    while (c < n && b < 300) begin
      @(posedge clk); #1;
      if (copy[d] === 1'b1) c++;
      b++;
    end
  endtask

  initial begin : stimulus
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; s_valid[d] = 1'b0; s_data[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 40-bit load, words 01..05, back-to-back.
    set_words(0, 40'h0504030201, 8'h01, 64'h05_0403_0201, 1'b1);
    pulse_start(0); send_words(0, 1'b0); wait_done(0);

    // 36-bit load: upper nibble of word 4 never shifted.
    set_words(1, 40'h0504030201, 8'h01, 64'h5_0403_0201, 1'b1);
    pulse_start(1); send_words(1, 1'b0); wait_done(1);

    // Same 40-bit load with random valid gaps.
    set_words(0, 40'h0504030201, 8'h01, 64'h05_0403_0201, 1'b0);
    pulse_start(0); send_words(0, 1'b1); wait_done(0);

    // Abort after 13 shifts, then a clean reload.
    set_words(0, 40'h0504030201, 8'h01, 64'h05_0403_0201, 1'b1);
    stop_req = 1'b0;
    pulse_start(0);
    fork
      send_words(0, 1'b0);
      begin
        wait_copies(0, 13);
        abort[0] = 1'b1;
        stop_req = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
      end
    join
    repeat (3) @(posedge clk); #1;
    stop_req = 1'b0;
    pulse_start(0); send_words(0, 1'b0); wait_done(0);

    // Reset in the middle of a 36-bit load.
    set_words(1, 40'h0504030201, 8'h01, 64'h5_0403_0201, 1'b1);
    pulse_start(1);
    fork
      send_words(1, 1'b0);
      begin
        wait_copies(1, 5);
        rst      = 1'b1;
        stop_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    repeat (3) @(posedge clk); #1;
    stop_req = 1'b0;

    // Start pulsed while busy must not disturb the load.
    set_words(1, 40'h8100FF3CA5, 8'hE7, 64'h1_00FF_3CA5, 1'b1);
    pulse_start(1);
    fork
      send_words(1, 1'b0);
      begin
        wait_copies(1, 10);
        start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
      end
    join
    wait_done(1);

    // A third word pattern on the 40-bit instance.
    set_words(0, 40'h55EFBEADDE, 8'h77, 64'h55_EFBE_ADDE, 1'b1);
    pulse_start(0); send_words(0, 1'b0); wait_done(0);

`ifdef WEIGHT_LOADER_CHECK_EN
    // Wrong trailer must raise crc_err with done.
    set_words(0, 40'h0504030201, 8'hFF, 64'h05_0403_0201, 1'b1);
    pulse_start(0); send_words(0, 1'b0); wait_done(0);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter WORD_B, default 32: width of the input word stream.
REQ-002 SHALL have parameter WEIGHTS_B, default 10496: total weight bits the model's serial weight register holds.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: pulse that begins a load; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: cancels a load in progress.
REQ-007 SHALL have port s_valid, input, 1: word-stream valid.
REQ-008 SHALL have port s_ready, output, 1: word-stream ready.
REQ-009 SHALL have port s_data, input, WORD_B: word payload.
REQ-010 SHALL have port copy, output, 1: shift enable to the model's weight register.
REQ-011 SHALL have port k, output, 1: serial weight bit to the model.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when all WEIGHTS_B bits have been shifted.

Function
REQ-014 SHALL implement states IDLE, WAIT_WORD, SHIFT and DONE.
REQ-015 SHALL move IDLE->WAIT_WORD on start=1 and clear the total-bit counter.
REQ-016 SHALL assert s_ready only in WAIT_WORD; a transfer occurs when s_valid&&s_ready; it SHALL then load s_data into the shift buffer and go to SHIFT.
REQ-017 In SHIFT, SHALL drive copy=1 and k=buffer[0] every cycle, right-shift the buffer, and increment the word-bit and total-bit counters.
REQ-018 SHALL return SHIFT->WAIT_WORD after WORD_B bits unless the total-bit count has reached WEIGHTS_B.
REQ-019 SHALL go to DONE on the cycle the WEIGHTS_B-th bit is shifted, even mid-word; the remaining pad bits of the last word SHALL be discarded and never shifted.
REQ-020 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL send bit order LSB-first, word 0 first, so that weights bit i is the i-th bit shifted; after the load the model's register holds weights[WEIGHTS_B-1:0] with bit 0 at its LSB.
REQ-022 SHALL hold copy=0 and k=0 outside SHIFT; a stalled upstream (s_valid=0) SHALL insert copy=0 gaps without corrupting order.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on abort=1 in any state, go to IDLE next cycle with copy=0 and no done pulse; abort SHALL take priority over a simultaneous transfer or a final shift.
REQ-025 SHALL size the counters as $clog2(WORD_B+1) and $clog2(WEIGHTS_B+1) bits; counters SHALL never wrap during a load.
REQ-026 Minimum latency from start to done SHALL be ceil(WEIGHTS_B/WORD_B) transfer cycles + WEIGHTS_B shift cycles + 2.

Reset
REQ-027 SHALL, on rst=1, enter IDLE and clear the counters and buffer, with s_ready=0, copy=0, k=0, busy=0, done=0; rst mid-load SHALL discard the partial load.

Configuration
REQ-028 With WEIGHT_LOADER_CHECK_EN defined, SHALL accept one trailer word after the last data word, compare it with the XOR of all data words, and drive an extra output port crc_err (1 bit) during the done pulse: 1 on mismatch, 0 otherwise; crc_err SHALL be 0 at all other times and after reset.
REQ-029 Without WEIGHT_LOADER_CHECK_EN, SHALL have no trailer word and no crc_err port.

Structure
REQ-030 SHALL take the state enum and the default WEIGHTS_B/WORD_B constants from the shared package model_pkg, so that the loader and the model agree on weight width.
REQ-031 SHALL put the buffer and bit counter in one sub-module, wl_piso (parallel-in serial-out); the FSM stays in weight_loader.

Verification
REQ-032 Test: WORD_B=8, WEIGHTS_B=40, start, words 0x01,0x02,0x03,0x04,0x05 with no gaps -> 40 copy cycles; k sequence equals the bits LSB-first; done pulses once; model register = 0x0504030201.
REQ-033 Test: WEIGHTS_B=36, 5 words -> exactly 36 copy cycles; the upper 4 bits of word 4 are never shifted; done fires the cycle after bit 35.
REQ-034 Test: random s_valid gaps (50% duty) on the REQ-032 load -> identical k sequence and final register; copy=0 during every gap.
REQ-035 Test: abort after 13 shift cycles -> IDLE next cycle; no done pulse; a new start reloads from bit 0 correctly.
REQ-036 Test: rst during SHIFT, then start asserted during busy -> rst clears all outputs; a start while busy has no effect.
REQ-037 Test: with WEIGHT_LOADER_CHECK_EN, trailer 0x01 for the REQ-032 words (XOR = 0x01) -> crc_err=0; trailer 0xFF -> crc_err=1 during done.
